nbody_force_engine: RTL
=======================

// Module: nbody_force_engine
// PURPOSE
//  Parametrised pairwise-gravity accumulator for the N-body datapath: latches a target body i, accepts a
//  valid/ready stream of source bodies j, and returns the saturated fixed-point net force on i.
//  2D or 3D, configurable widths, self-pair skipping. Sits between the body-BRAM sequencer and the integrator.
// PARAMETERS
//  DIMS     2     spatial dimensions, 2 or 3; when 2, z inputs are ignored and f_z = 0
//  POS_W    16    signed position width; FRAC_W fraction bits (all fixed-point values share FRAC_W)
//  MASS_W   16    unsigned mass width
//  FRAC_W   8     fraction bits
//  IDX_W    8     body index width
//  ACC_W    32    signed force accumulator / output width
//  G        256   unsigned gravitational constant, fixed-point (1.0)
//  SOFT_SQ  0     softening^2, fixed-point, added to dist^2
// PORTS
//  clk       in   1          clock, all logic on rising edge
//  reset_n   in   1          asynchronous, active-low reset
//  start     in   1          latch i_* and begin a pass (honoured only in IDLE)
//  i_index   in   IDX_W      target body index
//  i_x,i_y,i_z in POS_W      target position (signed)
//  j_valid   in   1          source beat valid
//  j_ready   out  1          engine accepts a source beat
//  j_index   in   IDX_W      source body index
//  j_x,j_y,j_z in POS_W      source position (signed)
//  j_mass    in   MASS_W     source mass
//  j_last    in   1          final source beat of the pass
//  f_valid   out  1          result valid
//  f_ready   in   1          result consumed
//  f_x,f_y,f_z out ACC_W     net force (signed, saturated)
//  f_count   out  IDX_W+1    number of pairs that contributed
//  f_sat     out  1          any accumulator clamped during the pass
//  busy      out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: async clear of FSM (IDLE), pipeline valids, accumulators, f_count, f_sat; all outputs 0.
//  FSM: IDLE -start-> ACCUM; ACCUM -(j_valid&j_ready&j_last)-> DRAIN; DRAIN -(pipe empty)-> RESULT;
//   RESULT -(f_valid&f_ready)-> IDLE. start in any non-IDLE state is ignored.
//  On start: latch i_*; clear accumulators, f_count, f_sat in the same edge.
//  j_ready = (state==ACCUM). A beat transfers when j_valid & j_ready.
//  Self-pair: beat with j_index==i_index is accepted but enters the pipe as a bubble (not counted);
//   if it carries j_last, the ACCUM->DRAIN transition still occurs.
//  Pipeline (6 stages, one beat/cycle, no stall), all signed ops with sign extension:
//   S1 d = j - i per axis, POS_W+1 bits
//   S2 sq = d*d per axis
//   S3 dsq = (sum sq) >>> FRAC_W + SOFT_SQ
//   S4 inv = 2^(2*FRAC_W) / max(dsq,1), 32 bits; gm = (G*j_mass) >> FRAC_W
//   S5 mag = (gm*inv) >> FRAC_W, 64-bit intermediate
//   S6 c = (mag*d) >>> FRAC_W per axis; acc += c, saturating to ACC_W; f_count++
//  Latency: beat accepted at edge N updates acc at edge N+6.
//  Saturation: if acc+c overflows ACC_W, clamp to +max/-min and set f_sat (sticky for the pass).
//  DRAIN waits until all 6 stage valids are 0, then enters RESULT.
//  RESULT: f_valid=1; f_x/f_y/f_z/f_count/f_sat held stable until handshake; f_valid drops the cycle after.
//  f_* outputs reflect the live accumulators and are valid only while f_valid=1.
//  Async reset mid-pass discards everything; the next pass requires a new start.
//  DIMS==2: z terms are forced to 0 in S1, so f_z = 0.
// TESTING
//  Reset: assert reset_n=0 mid-ACCUM with 3 beats in flight -> busy=0, j_ready=0, f_valid=0, next start
//   yields f_count from the new pass only.
//  Unit pair: i=(0,0); single beat j=(256,0), mass=256, idx!=i, last -> f_x=256, f_y=0, f_count=1;
//   acc updates 6 cycles after accept.
//  Symmetry: j=(-256,0), other params as above -> f_x=-256, f_y=0.
//  Self-skip: i_index=2; stream idx 0..3 at (256,0) each, mass 256, last on idx3 -> f_count=3, f_x=768.
//  Backpressure: hold f_ready=0 for 10 cycles in RESULT, pulse start -> f_valid and f_* stable, start
//   ignored; f_ready=1 -> IDLE next cycle.
//  Saturation: ACC_W=12; 20 beats j=(256,0), mass=256 -> f_x=2047, f_sat=1, f_count=20.

Source files
------------

// File: rtl/nbody_force_engine.sv
// rtl/nbody_force_engine.sv - pairwise-gravity force accumulator, 6-stage pipeline, saturating output
module nbody_force_engine #(
  parameter int          DIMS    = 2,
  parameter int          POS_W   = 16,
  parameter int          MASS_W  = 16,
  parameter int          FRAC_W  = 8,
  parameter int          IDX_W   = 8,
  parameter int          ACC_W   = 32,
  parameter int unsigned G       = 256,
  parameter int unsigned SOFT_SQ = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [IDX_W-1:0]        i_index,
  input  logic signed [POS_W-1:0] i_x,
  input  logic signed [POS_W-1:0] i_y,
  input  logic signed [POS_W-1:0] i_z,
  input  logic                    j_valid,
  output logic                    j_ready,
  input  logic [IDX_W-1:0]        j_index,
  input  logic signed [POS_W-1:0] j_x,
  input  logic signed [POS_W-1:0] j_y,
  input  logic signed [POS_W-1:0] j_z,
  input  logic [MASS_W-1:0]       j_mass,
  input  logic                    j_last,
  output logic                    f_valid,
  input  logic                    f_ready,
  output logic signed [ACC_W-1:0] f_x,
  output logic signed [ACC_W-1:0] f_y,
  output logic signed [ACC_W-1:0] f_z,
  output logic [IDX_W:0]          f_count,
  output logic                    f_sat,
  output logic                    busy
);
  localparam int D_W   = POS_W + 1;
  localparam int SQ_W  = 2 * D_W;
  localparam int SUM_W = SQ_W + 2;
  localparam int C_W   = 64 + D_W + 1;
  localparam logic signed [C_W:0] ACC_MAX = {{(C_W-ACC_W+2){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [C_W:0] ACC_MIN = {{(C_W-ACC_W+2){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [63:0]         ONE_SQ  = 64'd1 << (2 * FRAC_W);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [POS_W-1:0] ip_q [3], ip_d [3];
  logic [5:0]              v_q, v_d;
  logic signed [D_W-1:0]   dp_q [5][3], dp_d [5][3];
  logic [MASS_W-1:0]       m_q [3], m_d [3];
  logic [SQ_W-1:0]         sq_q [3], sq_d [3];
  logic [SUM_W-1:0]        dsq_q, dsq_d;
  logic [31:0]             inv_q, inv_d;
  logic [63:0]             gm_q, gm_d, mag_q, mag_d;
  logic signed [C_W-1:0]   c_q [3], c_d [3];
  logic signed [ACC_W-1:0] acc_q [3], acc_d [3];
  logic [IDX_W:0]          cnt_q, cnt_d;
  logic                    sat_q, sat_d;

  logic                    accept, go;
  logic signed [POS_W-1:0] jp [3];
  logic [SUM_W-1:0]        sum_sq, den;
  logic signed [C_W:0]     acc_sum;

  assign accept = j_valid & j_ready;
  assign go     = start & (state_q == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)             state_d = ACCUM;
      ACCUM:   if (accept && j_last)  state_d = DRAIN;
      DRAIN:   if (v_q == '0)         state_d = RESULT;
      RESULT:  if (f_ready)           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    j_ready = (state_q == ACCUM);
    f_valid = (state_q == RESULT);
  end

  always_comb begin
    jp[0] = j_x;
    jp[1] = j_y;
    jp[2] = j_z;
    idx_d = go ? i_index : idx_q;
    ip_d  = ip_q;
    if (go) begin
      ip_d[0] = i_x;
      ip_d[1] = i_y;
      ip_d[2] = i_z;
    end
    // Self-pairs are accepted but travel as bubbles
    v_d = {v_q[4:0], accept && (j_index != idx_q)};
    for (int a = 0; a < 3; a++) begin
      dp_d[0][a] = (a < DIMS) ? D_W'(jp[a]) - D_W'(ip_q[a]) : '0;
      for (int s = 1; s < 5; s++) dp_d[s][a] = dp_q[s-1][a];
      sq_d[a] = SQ_W'(dp_q[0][a]) * SQ_W'(dp_q[0][a]);
      c_d[a]  = (C_W'($signed({1'b0, mag_q})) * C_W'(dp_q[4][a])) >>> FRAC_W;
    end
    m_d[0] = j_mass;
    m_d[1] = m_q[0];
    m_d[2] = m_q[1];
    sum_sq = SUM_W'(sq_q[0]) + SUM_W'(sq_q[1]) + SUM_W'(sq_q[2]);
    dsq_d  = (sum_sq >> FRAC_W) + SUM_W'(SOFT_SQ);
    den    = (dsq_q == '0) ? SUM_W'(1) : dsq_q;
    inv_d  = 32'(ONE_SQ / 64'(den));
    gm_d   = (64'(G) * 64'(m_q[2])) >> FRAC_W;
    mag_d  = (gm_q * 64'(inv_q)) >> FRAC_W;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    acc_sum = '0;
    if (go) begin
      acc_d = '{default: '0};
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (v_q[5]) begin
      cnt_d = cnt_q + (IDX_W+1)'(1);
      for (int a = 0; a < 3; a++) begin
        acc_sum = (C_W+1)'(acc_q[a]) + (C_W+1)'(c_q[a]);
        if (acc_sum > ACC_MAX) begin
          acc_d[a] = ACC_MAX[ACC_W-1:0];
          sat_d    = 1'b1;
        end else if (acc_sum < ACC_MIN) begin
          acc_d[a] = ACC_MIN[ACC_W-1:0];
          sat_d    = 1'b1;
        end else begin
          acc_d[a] = acc_sum[ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      ip_q  <= '{default: '0};
      v_q   <= '0;
      dp_q  <= '{default: '0};
      m_q   <= '{default: '0};
      sq_q  <= '{default: '0};
      dsq_q <= '0;
      inv_q <= '0;
      gm_q  <= '0;
      mag_q <= '0;
      c_q   <= '{default: '0};
      acc_q <= '{default: '0};
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      ip_q  <= ip_d;
      v_q   <= v_d;
      dp_q  <= dp_d;
      m_q   <= m_d;
      sq_q  <= sq_d;
      dsq_q <= dsq_d;
      inv_q <= inv_d;
      gm_q  <= gm_d;
      mag_q <= mag_d;
      c_q   <= c_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign f_x     = acc_q[0];
  assign f_y     = acc_q[1];
  assign f_z     = acc_q[2];
  assign f_count = cnt_q;
  assign f_sat   = sat_q;
endmodule
